serial_subtractor_16bit: RTL and testbench



---
 rtl/serial_subtractor_16bit_pkg.sv | 15 +
 rtl/serial_subtractor_16bit_if.sv | 28 ++
 rtl/serial_subtractor_16bit_full_subtractor.sv | 11 +
 rtl/serial_subtractor_16bit.sv | 110 +++++++++++
 tb/tb_serial_subtractor_16bit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The bit counter only needs to reach WIDTH-1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_16bit_if.sv
// Start/busy/done handshake bundle for serial_subtractor_16bit.
// Optional macro SUB_FLAGS_EN adds the zero/ovf result flags.
interface serial_subtractor_16bit_if #(
  parameter int WIDTH = sub_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout, zero, ovf);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout, zero, ovf);
`else
  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_16bit_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial a - b - bin, LSB first, one bit per clock under start/busy/done.
// Optional macro SUB_FLAGS_EN adds registered zero and signed-overflow flags.
module serial_subtractor_16bit
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_subtractor_16bit_if.slave  bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_diff_next;

  full_subtractor u_fs (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};

`ifdef SUB_FLAGS_EN
  logic r_zero;
  logic r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SUB_FLAGS_EN
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_br    <= bus.bin;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_diff <= w_diff_next;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_br   <= w_bo;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_bout  <= w_bo;
`ifdef SUB_FLAGS_EN
            // r_br is the borrow into the MSB, w_bo the borrow out of it.
            r_zero  <= (w_diff_next == '0);
            r_ovf   <= r_br ^ w_bo;
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SUB_FLAGS_EN
  assign bus.zero = r_zero;
  assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Bench for serial_subtractor_16bit: vector table, handshake corners, async reset, random vs model.
module tb_serial_subtractor_16bit;
  localparam int W = 16;

  logic clk;
  logic rst_n;

  serial_subtractor_16bit_if #(.WIDTH(W)) bus ();

  serial_subtractor_16bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_diff;
    logic        exp_bout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain signed-integer arithmetic on the operand values.
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int r;
    logic [31:0] rv;
    r  = int'(a) - int'(b) - int'(bin);
    rv = r;
    return {(r < 0), rv[15:0]};
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return (r < -32768) || (r > 32767);
  endfunction

  // Issue one op; returns at the negedge where done is seen (start left as the caller set it).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input bit mess, output int cyc);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mess && cyc == 5) begin
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
        bus.start = 1'b1;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic bin, input logic [15:0] ed, input logic eb, input int cyc);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_diff"}, {16'd0, bus.diff}, {16'd0, ed});
    check({tag, "_bout"}, {31'd0, bus.bout}, {31'd0, eb});
`ifdef SUB_FLAGS_EN
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, (ed == 16'd0)});
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, ref_ovf(a, b, bin)});
`else
    if (a == b && bin == 1'b0 && tag == "never") $display("unused");
`endif
  endtask

  initial begin
    int cyc;
    logic [16:0] m;
    logic [15:0] ra, rb;
    logic rbin;

    vecs[0] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0};
    vecs[1] = '{16'h5678, 16'h1234, 1'b1, 16'h4443, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
    vecs[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_diff", {16'd0, bus.diff}, 32'd0);
    check("reset_bout", {31'd0, bus.bout}, 32'd0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, cyc);
      check_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].exp_diff, vecs[i].exp_bout, cyc);
      @(negedge clk);
      check("busy_fall_after_done", {31'd0, bus.busy}, 32'd0);
      check("done_one_cycle", {31'd0, bus.done}, 32'd0);
      check("diff_held_idle", {16'd0, bus.diff}, {16'd0, vecs[i].exp_diff});
      $display("vec%0d a=%h b=%h bin=%0d diff=%h bout=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].bin, bus.diff, bus.bout);
    end

    // Async reset at cycle 8 of RUN, with stale bout=1 and partial diff bits set
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'h0000; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    check("pre_reset_bout", {31'd0, bus.bout}, 32'd1);
    check("pre_reset_diff_nonzero", {31'd0, (bus.diff != 16'd0)}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("async_rst_done", {31'd0, bus.done}, 32'd0);
    check("async_rst_bout", {31'd0, bus.bout}, 32'd0);
    check("async_rst_diff", {16'd0, bus.diff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, cyc);
    check_result("after_reset", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, cyc);
    $display("after_reset a=ffff b=ffff diff=%h bout=%0d", bus.diff, bus.bout);

    // Operands and start changed mid-RUN, start still high during the done cycle
    run_op(16'h1357, 16'h0246, 1'b1, 1'b1, cyc);
    check_result("mess", 16'h1357, 16'h0246, 1'b1, 16'h1110, 1'b0, cyc);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("still_idle", {31'd0, bus.busy}, 32'd0);
    $display("mess a=1357 b=0246 bin=1 diff=%h bout=%0d", bus.diff, bus.bout);

    // Start held high: one idle cycle after DONE, then the next accept
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0234; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!bus.done && cyc < 40) begin @(negedge clk); cyc++; end
    check_result("b2b_first", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, cyc);
    bus.a = 16'h0010; bus.b = 16'h0020;
    @(negedge clk);
    check("b2b_gap_idle", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("b2b_reaccept", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 40) begin @(negedge clk); cyc++; end
    check_result("b2b_second", 16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1, cyc);
    $display("b2b second diff=%h bout=%0d", bus.diff, bus.bout);

    // Randomized against the arithmetic model
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (n % 10 == 0) rb = ra;
      m = ref_sub(ra, rb, rbin);
      run_op(ra, rb, rbin, 1'b0, cyc);
      check_result("rand", ra, rb, rbin, m[15:0], m[16], cyc);
      if (n < 10)
        $display("rand%0d a=%h b=%h bin=%0d diff=%h bout=%0d", n, ra, rb, rbin, bus.diff, bus.bout);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
